// File: rtl/mmio_responder_pkg.sv
// ----------------------------------------------------------------------------
// mmio_defs
//   Shared definitions for the IO-region responder: region select value,
//   register offsets, status bit positions and small address helpers.
//   The control path imports this too, to recognise IO-region loads.
// ----------------------------------------------------------------------------
package mmio_defs;

    // Value of addr[31:28] that routes an access to the IO region.
    localparam logic [3:0] IO_REGION_DEFAULT = 4'h8;

    // Word offsets inside the IO region (addr[7:0] with addr[1:0] cleared).
    localparam logic [7:0] OFS_STATUS = 8'h00;
    localparam logic [7:0] OFS_RX     = 8'h04;
    localparam logic [7:0] OFS_TX     = 8'h08;
    localparam logic [7:0] OFS_CYC    = 8'h10;
    localparam logic [7:0] OFS_INST   = 8'h14;
    localparam logic [7:0] OFS_CLR    = 8'h18;

    // Status register bit positions.
    localparam int STAT_TX_RDY = 0;
    localparam int STAT_RX_VLD = 1;

    // Accesses are word granular: the byte-lane bits never affect decode.
    function automatic logic [7:0] word_offset(input logic [31:0] addr);
        return {addr[7:2], 2'b00};
    endfunction

    function automatic logic is_io(input logic [31:0] addr, input logic [3:0] region);
        return addr[31:28] == region;
    endfunction

endpackage

// File: rtl/mmio_responder_if.sv
// ----------------------------------------------------------------------------
// mmio_bus_if
//   Load/store bus between the core's control path and the IO responder.
//   master : core side   (drives address, data, strobes; receives rdata)
//   slave  : responder   (receives address, data, strobes; drives rdata)
//   Signals:
//     mmio_addr  [31:0]  byte address from the ALU result
//     mmio_wdata [31:0]  store data, already lane-shifted
//     mmio_we    [3:0]   byte write mask, all zero means no store
//     mmio_re            load strobe
//     mmio_rdata [31:0]  registered load data (one-cycle latency)
// ----------------------------------------------------------------------------
interface mmio_bus_if;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic [3:0]  mmio_we;
    logic        mmio_re;
    logic [31:0] mmio_rdata;

    modport master (
        output mmio_addr, mmio_wdata, mmio_we, mmio_re,
        input  mmio_rdata
    );

    modport slave (
        input  mmio_addr, mmio_wdata, mmio_we, mmio_re,
        output mmio_rdata
    );
endinterface

// File: rtl/mmio_responder_counter.sv
// ----------------------------------------------------------------------------
// mmio_counter
//   Free-running wrap-around counter with synchronous clear.
//   Ports:
//     clk    core clock
//     rst    synchronous active-high reset (zeroes the count)
//     clr    synchronous clear, wins over inc in the same cycle
//     inc    count enable for this cycle
//     count  [WIDTH-1:0] current value
// ----------------------------------------------------------------------------
module mmio_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // NOTE: state registers use non-blocking (<=) so every flop samples
    // the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/mmio_responder.sv
// ----------------------------------------------------------------------------
// mmio_responder
//   Answers loads and stores to the IO region (addr[31:28] == IO_REGION).
//   Register map (word offsets):
//     0x00 status  RO  bit0 = TX ready (~tx_valid), bit1 = RX byte available
//     0x04 RX data RO  {24'b0, uart_rx_data}; pops the receiver if valid
//     0x08 TX data WO  wdata[7:0] into the TX holding register
//     0x10 cycles  RO  free-running cycle counter (zero-extended)
//     0x14 instret RO  retired-instruction counter (zero-extended)
//     0x18 clear   WO  any store zeroes both counters
//   Ports:
//     clk, rst          core clock, synchronous active-high reset
//     bus               mmio_bus_if.slave load/store bus
//     inst_retired      one pulse per retired instruction
//     uart_tx_data/valid/ready   byte stream to the UART transmitter
//     uart_rx_data/valid/ready   byte stream from the UART receiver
// ----------------------------------------------------------------------------
module mmio_responder
    import mmio_defs::*;
#(
    parameter logic [3:0] IO_REGION = IO_REGION_DEFAULT,
    parameter int         CNT_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    mmio_bus_if.slave  bus,
    input  logic       inst_retired,
    output logic [7:0] uart_tx_data,
    output logic       uart_tx_valid,
    input  logic       uart_tx_ready,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_rx_valid,
    output logic       uart_rx_ready
);

    logic                 w_sel;
    logic [7:0]           w_ofs;
    logic                 w_rd;
    logic                 w_tx_wr;
    logic                 w_clr;
    logic [CNT_WIDTH-1:0] w_cyc_cnt;
    logic [CNT_WIDTH-1:0] w_inst_cnt;
    logic [31:0]          w_status;
    logic [31:0]          w_rd_mux;

    logic                 r_tx_valid;
    logic [7:0]           r_tx_data;
    logic [31:0]          r_rdata;

    // ---------------- decode ----------------
    assign w_sel   = is_io(bus.mmio_addr, IO_REGION);
    assign w_ofs   = word_offset(bus.mmio_addr);
    assign w_rd    = w_sel & bus.mmio_re;
    assign w_tx_wr = w_sel & bus.mmio_we[0] & (w_ofs == OFS_TX);
    assign w_clr   = w_sel & (|bus.mmio_we) & (w_ofs == OFS_CLR);

    // ---------------- counters ----------------
    mmio_counter #(.WIDTH(CNT_WIDTH)) u_cyc_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .inc   (1'b1),
        .count (w_cyc_cnt)
    );

    mmio_counter #(.WIDTH(CNT_WIDTH)) u_inst_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .inc   (inst_retired),
        .count (w_inst_cnt)
    );

    // ---------------- read mux ----------------
    // Status reflects the pre-edge TX state, so a status read that
    // coincides with a TX store or handshake sees the old tx_valid.
    // NOTE: every always_comb output gets a default first; otherwise an
    // unassigned path infers a latch.
    always_comb begin
        w_status              = '0;
        w_status[STAT_TX_RDY] = ~r_tx_valid;
        w_status[STAT_RX_VLD] = uart_rx_valid;
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_ofs)
            OFS_STATUS: w_rd_mux = w_status;
            OFS_RX:     w_rd_mux = {24'b0, uart_rx_data};
            OFS_CYC:    w_rd_mux = 32'(w_cyc_cnt);
            OFS_INST:   w_rd_mux = 32'(w_inst_cnt);
            default:    w_rd_mux = '0;
        endcase
    end

    // Registered read data holds its value between loads, matching the
    // synchronous data BRAM beside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_rd) begin
            r_rdata <= w_rd_mux;
        end
    end

    // ---------------- RX pop ----------------
    // Pop in the same cycle the byte is sampled into the read register;
    // held low during reset so a load in flight cannot consume a byte.
    assign uart_rx_ready = ~rst & w_rd & (w_ofs == OFS_RX) & uart_rx_valid;

    // ---------------- TX holding register ----------------
    // A store only lands when the register is empty; a store while a
    // byte is pending is dropped. Data stays put until the next accepted
    // store so the transmitter sees a stable byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else if (w_tx_wr && !r_tx_valid) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= bus.mmio_wdata[7:0];
        end else if (r_tx_valid && uart_tx_ready) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign uart_tx_valid  = r_tx_valid;
    assign uart_tx_data   = r_tx_data;
    assign bus.mmio_rdata = r_rdata;

endmodule
